// File: rtl/puvvada_says_defs.sv
// Shared definitions for the button conditioning path.
//   db_state_t  : per-button debounce FSM states
//   BTN_*       : bit positions of each direction in the 4-bit button vectors
//   CODE_*      : 2-bit event codes presented to the game state machine
//   prio_code() : maps a pulse vector to the code of its highest-priority button
package puvvada_says_defs;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } db_state_t;

    localparam logic [1:0] BTN_U = 2'd3;
    localparam logic [1:0] BTN_R = 2'd2;
    localparam logic [1:0] BTN_D = 2'd1;
    localparam logic [1:0] BTN_L = 2'd0;

    localparam logic [1:0] CODE_U = 2'd0;
    localparam logic [1:0] CODE_R = 2'd1;
    localparam logic [1:0] CODE_D = 2'd2;
    localparam logic [1:0] CODE_L = 2'd3;

    // Priority U > R > D > L; caller guarantees at least one bit is set.
    function automatic logic [1:0] prio_code(input logic [3:0] pulses);
        if (pulses[BTN_U])      return CODE_U;
        else if (pulses[BTN_R]) return CODE_R;
        else if (pulses[BTN_D]) return CODE_D;
        else                    return CODE_L;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchronizer, debounce FSM with a
// stability counter, registered press strobe and debounced level.
//   board_clk : system clock
//   Reset     : asynchronous, active-high
//   raw       : raw button input, asynchronous to board_clk
//   level     : debounced level (high while PRESSED / WAIT_RELEASE)
//   pulse     : one-cycle strobe per accepted press
module btn_debounce
    import puvvada_says_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             s;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_next;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            meta  <= 1'b0;
            s     <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            meta  <= raw;
            s     <= meta;
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
            // Level follows the current state, so it trails the FSM by one edge.
            level <= (state == ST_PRESSED) || (state == ST_WAIT_RELEASE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_next = ST_WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!s) begin
                    state_next = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_PRESSED;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_next = ST_WAIT_RELEASE;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (s) begin
                    state_next = ST_PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the U/R/D/L buttons and latches one press event until the
// slow-clock consumer acknowledges it.
//   board_clk   : 100 MHz system clock
//   Reset       : asynchronous, active-high
//   btn_raw     : raw buttons {U,R,D,L} = [3:0]
//   evt_ack     : acknowledge level from the slow domain; rising edge consumes
//   btn_level   : debounced button levels
//   btn_pulse   : one-cycle strobe per accepted press
//   evt_valid   : an unconsumed event is held
//   evt_code    : held event code (U=0, R=1, D=2, L=3)
//   evt_overrun : sticky, a press arrived while an event was held
module btn_conditioner
    import puvvada_says_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic [3:0] btn_raw,
    input  logic       evt_ack,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_overrun
);

    logic       ack_meta;
    logic       ack_s;
    logic       ack_s_d;
    logic       ack_rise;
    logic       valid_next;
    logic       overrun_next;
    logic [1:0] code_next;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .board_clk(board_clk),
                .Reset    (Reset),
                .raw      (btn_raw[i]),
                .level    (btn_level[i]),
                .pulse    (btn_pulse[i])
            );
        end
    endgenerate

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            ack_meta    <= 1'b0;
            ack_s       <= 1'b0;
            ack_s_d     <= 1'b0;
            ack_rise    <= 1'b0;
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_overrun <= 1'b0;
        end else begin
            ack_meta    <= evt_ack;
            ack_s       <= ack_meta;
            ack_s_d     <= ack_s;
            // Registered edge so the latch sees it in step with the registered pulses.
            ack_rise    <= ack_s & ~ack_s_d;
            evt_valid   <= valid_next;
            evt_code    <= code_next;
            evt_overrun <= overrun_next;
        end
    end

    // Ack clears first, so a press coinciding with the ack is captured, not an overrun.
    always_comb begin
        valid_next   = evt_valid & ~ack_rise;
        overrun_next = evt_overrun & ~ack_rise;
        code_next    = evt_code;
        if (|btn_pulse) begin
            if (!valid_next) begin
                valid_next = 1'b1;
                code_next  = prio_code(btn_pulse);
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Debounces the four direction buttons (U, R, D, L) on board_clk and turns each clean press into a single latched event for the game state machine. The state machine runs on the slow divided clock, so one-cycle pulses would be missed; this block holds one event (valid + 2-bit code) until the consumer acknowledges it. It sits between the raw BtnU/BtnR/BtnD/BtnL pins and the state machine's button inputs, and also feeds the VGA block controller.

## Interface
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a press or release (10 ms at 100 MHz); must be ≥ 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

- board_clk  in  1  100 MHz system clock
- Reset  in  1  asynchronous, active-high
- btn_raw  in  4  raw buttons, bit order {U,R,D,L} = [3:0], asynchronous to board_clk
- evt_ack  in  1  consumer acknowledge, level from the slow clock domain; a rising edge consumes the event
- btn_level  out  4  debounced button levels
- btn_pulse  out  4  one-cycle strobe per accepted press
- evt_valid  out  1  an unconsumed event is held
- evt_code  out  2  held event: U=0, R=1, D=2, L=3
- evt_overrun  out  1  sticky; a press arrived while evt_valid=1

## Operation
- Each btn_raw bit passes through a 2-FF synchronizer, giving s[i].
- Per-button FSM (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE), counter cnt[i]:
  - IDLE: s=1 → WAIT_PRESS, cnt=0.
  - WAIT_PRESS: s=0 → IDLE. s=1 with cnt==DEBOUNCE_CYCLES-1 → PRESSED and btn_pulse[i]=1 for that one cycle. Otherwise cnt++.
  - PRESSED: s=0 → WAIT_RELEASE, cnt=0.
  - WAIT_RELEASE: s=1 → PRESSED, with no pulse. s=0 with cnt==DEBOUNCE_CYCLES-1 → IDLE. Otherwise cnt++.
  - btn_level[i]=1 in PRESSED and WAIT_RELEASE.
- Glitch rule: a bounce shorter than DEBOUNCE_CYCLES never produces a pulse and never toggles btn_level.
- evt_ack passes through a 2-FF synchronizer plus an edge detector, giving ack_rise.
- Event latch, evaluated each cycle in this order:
  1. ack_rise clears evt_valid and evt_overrun.
  2. If any btn_pulse is high and evt_valid is 0 after step 1: capture the highest-priority pulse (U > R > D > L), set evt_valid, load evt_code.
  3. If any btn_pulse is high and evt_valid is still 1: set evt_overrun. evt_code is unchanged, so the first press wins.
- Simultaneous pulses in one cycle: the highest-priority pulse is captured. Overrun is not set by the lower-priority pulses in that same cycle.
- ack_rise with no event held: no effect.

## Timing
- Reset values: all outputs 0. All FSMs go to IDLE, counters to 0, synchronizers to 0.
- Reset asserted mid-count or while an event is held: immediate clear; the held event is lost.
- Press latency: raw first sampled 1 at edge k, held stable → btn_pulse high in the cycle after edge k+DEBOUNCE_CYCLES+2. evt_valid and evt_code are registered one edge later.
- Release latency: btn_level falls DEBOUNCE_CYCLES+3 edges after raw is first sampled 0.
- Ack latency: evt_valid falls 3 edges after evt_ack is first sampled high.
- The consumer must hold evt_ack for at least 3 board_clk cycles. The slow-domain level satisfies this by construction.

## Structure
- Shared definitions file puvvada_says_defs:
  - FSM state encodings (2 bits)
  - button index constants BTN_U=3, BTN_R=2, BTN_D=1, BTN_L=0
  - event codes CODE_U..CODE_L
- Sub-module btn_debounce: synchronizer, FSM, counter and pulse for one button, parameterised by DEBOUNCE_CYCLES and CNT_W. Instantiated 4×.
- Top level holds the ack synchronizer, the priority encoder and the event latch.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, CNT_W=4.
- Clean press: btn_raw=4'b1000 held 20 cycles → one btn_pulse[3] at cycle 11 after the first sample; evt_valid=1, evt_code=0 one cycle later; btn_level[3]=1 until the release completes.
- Bounce: btn_raw[1] toggles every 3 cycles for 30 cycles, then returns low → btn_pulse, btn_level and evt_valid stay 0 throughout.
- Priority and overrun:
  - btn_raw=4'b0101 (R and L) rising together → evt_code=1 (R), evt_overrun=0.
  - Then a clean press of U while evt_valid=1 → evt_code stays 1, evt_overrun=1.
- Ack:
  - evt_ack high for 4 cycles → evt_valid and evt_overrun are 0 three edges after the first sample.
  - A second ack edge with no event held → no change.
- Ack coincident with a press: align ack_rise with btn_pulse[0] → evt_valid stays 1, evt_code=3, evt_overrun=0.
- Reset mid-operation: assert Reset during WAIT_PRESS with an event held → all outputs 0 immediately. After release, a stable press still takes the full 11 cycles to its pulse.
